key_seq_driver: RTL and testbench

//   Transmit side of the key interface used by the locked FSM benchmarks.
//   - Accepts a logic-locking key serially, one bit per handshake.
//   - Drives the KEY_W-bit keyinput bus that a locked FSM (e.g. e191 family) samples combinationally.
//   - Holds the DUT in reset while the key changes and releases it only after a settle window.
//   - Sits between the test/activation controller and the locked core's keyinput/rst pins.

---
 rtl/lock_pkg.sv | 18 +
 rtl/key_shift_reg.sv | 41 ++++
 rtl/key_seq_driver.sv | 127 ++++++++++++
 tb/tb_key_seq_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the key driver and the locked FSM benchmarks it feeds.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    ARMED  = 2'd3
  } drv_state_t;

  localparam int KEY_W_DEFAULT = 8;

  // Key widths of the locked benchmark families driven by this block.
  localparam int E191_KEY_W = 8;
  localparam int E192_KEY_W = 16;
  localparam int E193_KEY_W = 32;

endpackage

// File: rtl/key_shift_reg.sv
// Serial-in shadow register for the incoming key, with bit counter and full flag.
module key_shift_reg #(
  parameter int KEY_W = 8,
  localparam int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [KEY_W-1:0] next_shadow,
  output logic             last,
  output logic             full
);

  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] bit_cnt;

  // Value the shadow takes if bit_in is shifted in this cycle (MSB first).
  generate
    if (KEY_W == 1) begin : g_one
      assign next_shadow = bit_in;
    end else begin : g_many
      assign next_shadow = {shadow[KEY_W-2:0], bit_in};
    end
  endgenerate

  assign last = (bit_cnt == CNT_W'(KEY_W - 1));
  assign full = (bit_cnt == CNT_W'(KEY_W));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (shift && !full) begin
      shadow  <= next_shadow;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_seq_driver.sv
// Loads a locking key serially, presents it on keyinput, and holds the locked
// core in reset until the new key has been stable for SETTLE_N cycles.
module key_seq_driver
  import lock_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEFAULT,
  parameter int SETTLE_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  input  logic             key_abort,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             dut_rst,
  output logic             busy,
  output logic             err_abort
);

  localparam int SW = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;

  // Handshake: a key bit moves only in a cycle where key_bit_valid and
  // key_bit_ready are both high; ready is high exactly while in SHIFT.
  drv_state_t       state, state_n;
  logic [KEY_W-1:0] keyinput_n;
  logic             key_valid_n, dut_rst_n, busy_n, err_abort_n;
  logic [SW-1:0]    settle_cnt, settle_cnt_n;
  logic             sr_clear, sr_shift, sr_last, sr_full, xfer;
  logic [KEY_W-1:0] sr_next;

  key_shift_reg #(.KEY_W(KEY_W)) u_shift (
    .clk         (clk),
    .rst         (rst),
    .clear       (sr_clear),
    .shift       (sr_shift),
    .bit_in      (key_bit),
    .next_shadow (sr_next),
    .last        (sr_last),
    .full        (sr_full)
  );

  assign key_bit_ready = (state == SHIFT);
  assign xfer          = key_bit_valid && key_bit_ready && !sr_full;

  always_comb begin
    state_n      = state;
    keyinput_n   = keyinput;
    key_valid_n  = key_valid;
    dut_rst_n    = dut_rst;
    busy_n       = busy;
    err_abort_n  = err_abort;
    settle_cnt_n = settle_cnt;
    sr_clear     = 1'b0;
    sr_shift     = 1'b0;
    case (state)
      IDLE, ARMED: begin
        if (state == IDLE) begin
          dut_rst_n = !key_valid;
          busy_n    = 1'b0;
        end
        if (load_start) begin
          state_n     = SHIFT;
          sr_clear    = 1'b1;
          key_valid_n = 1'b0;
          dut_rst_n   = 1'b1;
          err_abort_n = 1'b0;
          busy_n      = 1'b1;
        end
      end
      SHIFT: begin
        // Abort beats restart beats a bit transfer; the losers are discarded.
        if (key_abort) begin
          state_n     = IDLE;
          key_valid_n = 1'b0;
          err_abort_n = 1'b1;
          dut_rst_n   = 1'b1;
          busy_n      = 1'b0;
        end else if (load_start) begin
          sr_clear = 1'b1;
        end else if (xfer) begin
          sr_shift = 1'b1;
          if (sr_last) begin
            keyinput_n   = sr_next;
            settle_cnt_n = '0;
            state_n      = SETTLE;
          end
        end
      end
      SETTLE: begin
        dut_rst_n = 1'b1;
        if (settle_cnt == SW'(SETTLE_N - 1)) begin
          state_n     = ARMED;
          key_valid_n = 1'b1;
          dut_rst_n   = 1'b0;
          busy_n      = 1'b0;
        end else begin
          settle_cnt_n = settle_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      keyinput   <= '0;
      key_valid  <= 1'b0;
      dut_rst    <= 1'b1;
      busy       <= 1'b0;
      err_abort  <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      keyinput   <= keyinput_n;
      key_valid  <= key_valid_n;
      dut_rst    <= dut_rst_n;
      busy       <= busy_n;
      err_abort  <= err_abort_n;
      settle_cnt <= settle_cnt_n;
    end
  end

endmodule

// File: tb/tb_key_seq_driver.sv
// Bench for key_seq_driver: directed scenarios plus randomized loads, with a
// key scoreboard checked whenever the driver announces a settled key.
module tb_key_seq_driver;

  localparam int KEY_W    = 8;
  localparam int SETTLE_N = 4;

  logic             clk;
  logic             rst;
  logic             load_start;
  logic             key_bit;
  logic             key_bit_valid;
  logic             key_bit_ready;
  logic             key_abort;
  logic [KEY_W-1:0] keyinput;
  logic             key_valid;
  logic             dut_rst;
  logic             busy;
  logic             err_abort;

  key_seq_driver #(.KEY_W(KEY_W), .SETTLE_N(SETTLE_N)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .key_bit       (key_bit),
    .key_bit_valid (key_bit_valid),
    .key_bit_ready (key_bit_ready),
    .key_abort     (key_abort),
    .keyinput      (keyinput),
    .key_valid     (key_valid),
    .dut_rst       (dut_rst),
    .busy          (busy),
    .err_abort     (err_abort)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard state ----------------
  int               total = 0;
  int               bad   = 0;
  logic [KEY_W-1:0] exp_q[$];
  logic [KEY_W-1:0] cur_key;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic             kv_prev = 1'b0;
  logic             dr_prev = 1'b1;
  logic [KEY_W-1:0] ki_prev = '0;
  logic [KEY_W-1:0] exp_key;

  always @(negedge clk) begin
    if (rst) begin
      kv_prev = 1'b0;
      dr_prev = 1'b1;
      ki_prev = keyinput;
    end else begin
      if (key_valid && !kv_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key_valid got=%0h exp=none", keyinput);
        end else begin
          exp_key = exp_q.pop_front();
          check("armed_key", keyinput, exp_key);
          check("armed_dut_rst", dut_rst, 0);
        end
      end
      if (!dr_prev && !dut_rst) check("key_stable_while_released", keyinput, ki_prev);
      kv_prev = key_valid;
      dr_prev = dut_rst;
      ki_prev = keyinput;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_abort();
    key_abort = 1'b1;
    tick();
    key_abort = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    logic rdy;
    rdy = 1'b0;
    repeat (gap) tick();
    key_bit       = b;
    key_bit_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rdy = key_bit_ready;
      tick();
      if (rdy) break;
    end
    if (!rdy) check("ready_timeout", 0, 1);
    key_bit_valid = 1'b0;
    key_bit       = 1'($urandom_range(0, 1));
  endtask

  // Sends a whole key MSB first; the model's committed key is the bit sequence read as a number.
  task automatic send_key(input logic [KEY_W-1:0] k, input int max_gap, input bit push);
    int value;
    value = 0;
    if (push) exp_q.push_back(k);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      send_bit(k[i], $urandom_range(0, max_gap));
      value = value * 2 + int'(k[i]);
      if (i > 0) check("key_hold_during_load", keyinput, cur_key);
    end
    check("key_after_last_bit", keyinput, value);
    if (push) cur_key = KEY_W'(value);
  endtask

  task automatic wait_armed();
    for (int n = 0; n < SETTLE_N + 10; n++) begin
      if (key_valid) break;
      tick();
    end
    check("wait_armed", key_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [KEY_W-1:0] k;
    int               r, nb;

    rst = 1'b1; load_start = 1'b0; key_bit = 1'b0; key_bit_valid = 1'b0; key_abort = 1'b0;
    cur_key = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset then idle.
    repeat (5) tick();
    check("rst_keyinput", keyinput, 0);
    check("rst_dut_rst", dut_rst, 1);
    check("rst_key_valid", key_valid, 0);
    check("rst_ready", key_bit_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_abort, 0);

    // Back-to-back load of 8'hB2 with exact settle latency.
    pulse_load();
    check("shift_ready", key_bit_ready, 1);
    check("shift_busy", busy, 1);
    send_key(8'hB2, 0, 1);
    check("latency_dut_rst_t1", dut_rst, 1);
    check("latency_key_valid_t1", key_valid, 0);
    check("settle_ready_low", key_bit_ready, 0);
    for (int c = 1; c < SETTLE_N; c++) begin
      tick();
      check("settle_key_valid_low", key_valid, 0);
      check("settle_dut_rst_high", dut_rst, 1);
    end
    tick();
    check("armed_key_valid", key_valid, 1);
    check("armed_dut_rst_low", dut_rst, 0);
    check("armed_busy", busy, 0);

    // Same key with gaps of 0..3 cycles.
    pulse_load();
    send_key(8'hB2, 3, 1);
    check("gap_key", keyinput, 8'hB2);
    wait_armed();
    check("armed_ready_low", key_bit_ready, 0);

    // Reload 8'h01 from ARMED.
    pulse_load();
    check("reload_dut_rst", dut_rst, 1);
    check("reload_key_valid", key_valid, 0);
    check("reload_keep_old", keyinput, 8'hB2);
    send_key(8'h01, 1, 1);
    wait_armed();

    // Abort after 5 bits.
    pulse_load();
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 0);
    pulse_abort();
    check("abort_err", err_abort, 1);
    check("abort_ready", key_bit_ready, 0);
    check("abort_keyinput", keyinput, cur_key);
    check("abort_dut_rst", dut_rst, 1);
    check("abort_key_valid", key_valid, 0);
    check("abort_busy", busy, 0);
    tick(); tick();
    check("abort_dut_rst_hold", dut_rst, 1);

    // Abort and load_start together (with a bit offered) while shifting.
    pulse_load();
    check("load_clears_err", err_abort, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    load_start = 1'b1; key_abort = 1'b1; key_bit = 1'b1; key_bit_valid = 1'b1;
    tick();
    load_start = 1'b0; key_abort = 1'b0; key_bit_valid = 1'b0;
    check("abort_beats_load_err", err_abort, 1);
    check("abort_beats_load_ready", key_bit_ready, 0);
    check("abort_beats_load_key", keyinput, cur_key);

    // rst while settling.
    pulse_load();
    send_key(8'h5A, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_settle_keyinput", keyinput, 0);
    check("rst_settle_dut_rst", dut_rst, 1);
    check("rst_settle_key_valid", key_valid, 0);
    check("rst_settle_busy", busy, 0);
    check("rst_settle_err", err_abort, 0);
    check("rst_settle_ready", key_bit_ready, 0);
    cur_key = '0;

    // Randomized loads with restarts and aborts.
    for (int it = 0; it < 40; it++) begin
      k  = KEY_W'($urandom);
      r  = $urandom_range(0, 9);
      nb = $urandom_range(1, KEY_W - 1);
      pulse_load();
      if (r < 2) begin
        for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        load_start = 1'b1; key_bit = 1'b1; key_bit_valid = 1'b1;
        tick();
        load_start = 1'b0; key_bit_valid = 1'b0;
      end
      if (r == 2 || r == 3) begin
        for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        pulse_abort();
        check("rand_abort_err", err_abort, 1);
        check("rand_abort_key", keyinput, cur_key);
        check("rand_abort_dut_rst", dut_rst, 1);
      end else begin
        send_key(k, 3, 1);
        wait_armed();
        check("rand_err_clear", err_abort, 0);
      end
    end

    repeat (10) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
